// File: rtl/jring_counter.sv
// Ring / Johnson counter with selectable direction, seed load and illegal-state correction.
// Outputs are fully registered; idx tracks position since the last reset, load or correction.
module jring_counter #(
   parameter  int WIDTH = 4,
   localparam int IW    = $clog2(2*WIDTH)
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             en,
   input  logic             mode,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] q,
   output logic [IW-1:0]    idx,
   output logic             wrap,
   output logic             err
);

   logic [WIDTH-1:0] q_nxt;
   logic [IW-1:0]    idx_nxt;
   logic             wrap_nxt;
   logic             err_nxt;

   logic [IW-1:0]    p_last;
   logic [WIDTH-1:0] rst_pat;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] q_inv;
   logic             legal_ring;
   logic             legal_john;
   logic             legal;

   assign p_last  = mode ? IW'(2*WIDTH-1) : IW'(WIDTH-1);
   assign rst_pat = mode ? '0 : WIDTH'(1);
   assign q_inv   = ~q;

   // Johnson-legal means a contiguous run of ones anchored at the LSB, or its complement.
   assign legal_ring = $onehot(q);
   assign legal_john = ((q & (q + WIDTH'(1))) == '0) || ((q_inv & (q_inv + WIDTH'(1))) == '0);
   assign legal      = (mode ? legal_john : legal_ring) && (idx <= p_last);

   always_comb begin
      shifted = q;
      case ({mode, dir})
         2'b00:   shifted = {q[WIDTH-2:0], q[WIDTH-1]};
         2'b01:   shifted = {q[0], q[WIDTH-1:1]};
         2'b10:   shifted = {q[WIDTH-2:0], ~q[WIDTH-1]};
         default: shifted = {~q[0], q[WIDTH-1:1]};
      endcase
   end

   always_comb begin
      q_nxt    = q;
      idx_nxt  = idx;
      wrap_nxt = 1'b0;
      err_nxt  = 1'b0;
      if (load) begin
         q_nxt   = seed;
         idx_nxt = '0;
      end else if (en) begin
         if (!legal) begin
            q_nxt   = rst_pat;
            idx_nxt = '0;
            err_nxt = 1'b1;
         end else begin
            q_nxt = shifted;
            if (!dir) begin
               if (idx == p_last) begin
                  idx_nxt  = '0;
                  wrap_nxt = 1'b1;
               end else begin
                  idx_nxt = idx + IW'(1);
               end
            end else begin
               if (idx == '0) begin
                  idx_nxt  = p_last;
                  wrap_nxt = 1'b1;
               end else begin
                  idx_nxt = idx - IW'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         q    <= rst_pat;
         idx  <= '0;
         wrap <= 1'b0;
         err  <= 1'b0;
      end else begin
         q    <= q_nxt;
         idx  <= idx_nxt;
         wrap <= wrap_nxt;
         err  <= err_nxt;
      end
   end

endmodule

// File: tb/tb_jring_counter.sv
// Directed bench for jring_counter (WIDTH=4) with hand-computed expected sequences.
module tb_jring_counter;

   localparam int WIDTH = 4;
   localparam int IW    = 3;

   logic             clk = 1'b0;
   logic             clr_n, en, mode, dir, load;
   logic [WIDTH-1:0] seed;
   logic [WIDTH-1:0] q;
   logic [IW-1:0]    idx;
   logic             wrap, err;

   int tests = 0;
   int fails = 0;

   jring_counter #(.WIDTH(WIDTH)) dut (
      .clk(clk), .clr_n(clr_n), .en(en), .mode(mode), .dir(dir),
      .load(load), .seed(seed), .q(q), .idx(idx), .wrap(wrap), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic m);
      clr_n = 1'b0; en = 1'b0; load = 1'b0; mode = m; dir = 1'b0; seed = '0;
      tick();
      clr_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset(1'b0);
      tests++;
      if (q !== 4'b0001 || idx !== 3'd0 || wrap !== 1'b0 || err !== 1'b0) begin
         fails++;
         $display("FAIL reset_ring: got q=%b idx=%0d wrap=%b err=%b, want q=0001 idx=0 wrap=0 err=0", q, idx, wrap, err);
      end
      do_reset(1'b1);
      tests++;
      if (q !== 4'b0000 || idx !== 3'd0 || wrap !== 1'b0 || err !== 1'b0) begin
         fails++;
         $display("FAIL reset_johnson: got q=%b idx=%0d wrap=%b err=%b, want q=0000 idx=0 wrap=0 err=0", q, idx, wrap, err);
      end
   endtask

   task automatic test_ring_up();
      logic [3:0] eq [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      logic [2:0] ei [5] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
      logic       ew [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      do_reset(1'b0);
      en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         tests++;
         if (q !== eq[i] || idx !== ei[i] || wrap !== ew[i] || err !== 1'b0) begin
            fails++;
            $display("FAIL ring_up[%0d]: got q=%b idx=%0d wrap=%b err=%b, want q=%b idx=%0d wrap=%b err=0",
                     i, q, idx, wrap, err, eq[i], ei[i], ew[i]);
         end
      end
      en = 1'b0;
      tick();
      tests++;
      if (q !== 4'b0010 || idx !== 3'd1 || wrap !== 1'b0 || err !== 1'b0) begin
         fails++;
         $display("FAIL hold: got q=%b idx=%0d wrap=%b err=%b, want q=0010 idx=1 wrap=0 err=0", q, idx, wrap, err);
      end
   endtask

   task automatic test_ring_down();
      logic [3:0] eq [3] = '{4'b1000, 4'b0100, 4'b0010};
      logic [2:0] ei [3] = '{3'd3, 3'd2, 3'd1};
      logic       ew [3] = '{1'b1, 1'b0, 1'b0};
      do_reset(1'b0);
      en = 1'b1; dir = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (q !== eq[i] || idx !== ei[i] || wrap !== ew[i] || err !== 1'b0) begin
            fails++;
            $display("FAIL ring_down[%0d]: got q=%b idx=%0d wrap=%b err=%b, want q=%b idx=%0d wrap=%b err=0",
                     i, q, idx, wrap, err, eq[i], ei[i], ew[i]);
         end
      end
      en = 1'b0; dir = 1'b0;
   endtask

   task automatic test_johnson_up();
      logic [3:0] eq [9] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};
      logic [2:0] ei [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
      do_reset(1'b1);
      en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         tests++;
         if (q !== eq[i] || idx !== ei[i] || wrap !== (i == 7) || err !== 1'b0) begin
            fails++;
            $display("FAIL johnson_up[%0d]: got q=%b idx=%0d wrap=%b err=%b, want q=%b idx=%0d wrap=%b err=0",
                     i, q, idx, wrap, err, eq[i], ei[i], (i == 7));
         end
      end
      en = 1'b0;
   endtask

   task automatic test_johnson_down();
      do_reset(1'b1);
      en = 1'b1; dir = 1'b1;
      tick();
      tests++;
      if (q !== 4'b1000 || idx !== 3'd7 || wrap !== 1'b1 || err !== 1'b0) begin
         fails++;
         $display("FAIL johnson_down0: got q=%b idx=%0d wrap=%b err=%b, want q=1000 idx=7 wrap=1 err=0", q, idx, wrap, err);
      end
      tick();
      tests++;
      if (q !== 4'b1100 || idx !== 3'd6 || wrap !== 1'b0 || err !== 1'b0) begin
         fails++;
         $display("FAIL johnson_down1: got q=%b idx=%0d wrap=%b err=%b, want q=1100 idx=6 wrap=0 err=0", q, idx, wrap, err);
      end
      en = 1'b0; dir = 1'b0;
   endtask

   task automatic test_illegal_load();
      do_reset(1'b0);
      en = 1'b1; load = 1'b1; seed = 4'b0101;
      tick();
      load = 1'b0;
      tests++;
      if (q !== 4'b0101 || idx !== 3'd0 || wrap !== 1'b0 || err !== 1'b0) begin
         fails++;
         $display("FAIL load_seed: got q=%b idx=%0d wrap=%b err=%b, want q=0101 idx=0 wrap=0 err=0", q, idx, wrap, err);
      end
      tick();
      tests++;
      if (q !== 4'b0001 || idx !== 3'd0 || wrap !== 1'b0 || err !== 1'b1) begin
         fails++;
         $display("FAIL correct: got q=%b idx=%0d wrap=%b err=%b, want q=0001 idx=0 wrap=0 err=1", q, idx, wrap, err);
      end
      tick();
      tests++;
      if (q !== 4'b0010 || idx !== 3'd1 || wrap !== 1'b0 || err !== 1'b0) begin
         fails++;
         $display("FAIL after_correct: got q=%b idx=%0d wrap=%b err=%b, want q=0010 idx=1 wrap=0 err=0", q, idx, wrap, err);
      end
      en = 1'b0;
   endtask

   task automatic test_johnson_load();
      do_reset(1'b1);
      en = 1'b1; load = 1'b1; seed = 4'b0011;
      tick();
      load = 1'b0;
      tick();
      tests++;
      if (q !== 4'b0111 || idx !== 3'd1 || wrap !== 1'b0 || err !== 1'b0) begin
         fails++;
         $display("FAIL johnson_load_step: got q=%b idx=%0d wrap=%b err=%b, want q=0111 idx=1 wrap=0 err=0", q, idx, wrap, err);
      end
      en = 1'b0;
   endtask

   task automatic test_reset_override();
      do_reset(1'b1);
      en = 1'b1;
      repeat (5) tick();
      tests++;
      if (q !== 4'b1110 || idx !== 3'd5) begin
         fails++;
         $display("FAIL pre_override: got q=%b idx=%0d, want q=1110 idx=5", q, idx);
      end
      clr_n = 1'b0; load = 1'b1; seed = 4'b1111;
      tick();
      clr_n = 1'b1; load = 1'b0; en = 1'b0;
      tests++;
      if (q !== 4'b0000 || idx !== 3'd0 || wrap !== 1'b0 || err !== 1'b0) begin
         fails++;
         $display("FAIL reset_override: got q=%b idx=%0d wrap=%b err=%b, want q=0000 idx=0 wrap=0 err=0", q, idx, wrap, err);
      end
   endtask

   task automatic test_mode_switch();
      do_reset(1'b1);
      en = 1'b1;
      repeat (6) tick();
      mode = 1'b0;
      tick();
      tests++;
      if (q !== 4'b0001 || idx !== 3'd0 || wrap !== 1'b0 || err !== 1'b1) begin
         fails++;
         $display("FAIL mode_switch: got q=%b idx=%0d wrap=%b err=%b, want q=0001 idx=0 wrap=0 err=1", q, idx, wrap, err);
      end
      tick();
      tests++;
      if (q !== 4'b0010 || idx !== 3'd1 || wrap !== 1'b0 || err !== 1'b0) begin
         fails++;
         $display("FAIL mode_switch_next: got q=%b idx=%0d wrap=%b err=%b, want q=0010 idx=1 wrap=0 err=0", q, idx, wrap, err);
      end
      en = 1'b0;
   endtask

   task automatic test_idx_range();
      // Johnson 1000 at idx 7 is a valid ring pattern, so only idx out of range flags it.
      do_reset(1'b1);
      en = 1'b1; dir = 1'b1;
      tick();
      mode = 1'b0; dir = 1'b0;
      tick();
      tests++;
      if (q !== 4'b0001 || idx !== 3'd0 || wrap !== 1'b0 || err !== 1'b1) begin
         fails++;
         $display("FAIL idx_range: got q=%b idx=%0d wrap=%b err=%b, want q=0001 idx=0 wrap=0 err=1", q, idx, wrap, err);
      end
      en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_ring_up();
      test_ring_down();
      test_johnson_up();
      test_johnson_down();
      test_illegal_load();
      test_johnson_load();
      test_reset_override();
      test_mode_switch();
      test_idx_range();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
